// File: rtl/uart_tx_fifo_if.sv
// Word-enqueue handshake into the UART transmit FIFO.
// The master drives in_data/in_valid; the FIFO answers with in_ready.
interface uart_tx_fifo_if #(
  parameter int W = 8
);
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a DEPTH-entry FIFO; tx falls one edge after a push into an idle, empty block.
// in_ready drops while the FIFO is full; queued frames go out back-to-back with no idle gap.
module uart_tx_fifo #(
  parameter int W     = 8,
  parameter int DIV   = 3,
  parameter int PAR   = 0,
  parameter int STOP  = 1,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  uart_tx_fifo_if.slave            s,
  output logic                     tx,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW    = $clog2(DEPTH);
  localparam int IW    = $clog2(W);
  localparam int STOPN = (STOP == 2) ? 2 : 1;
  localparam int CW    = $clog2(DIV * STOPN + 1);
  localparam bit PEN   = (PAR == 1) || (PAR == 2);

  localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(DIV * STOPN - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(W - 1);
  localparam logic [AW:0]   FULL      = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [W-1:0]  shreg;
  logic          par_bit;

  logic          push;
  logic          pop;
  logic          bit_end;
  logic          stop_end;
  logic [W-1:0]  head;

  assign s.in_ready = (level < FULL);
  assign busy       = (state != ST_IDLE);

  assign push     = s.in_valid && s.in_ready && !rst;
  assign bit_end  = (cnt == BIT_LAST);
  assign stop_end = (cnt == STOP_LAST);
  assign head     = mem[rd_ptr];
  assign pop      = (level != '0) &&
                    ((state == ST_IDLE) || ((state == ST_STOP) && stop_end));

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= s.in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // The popped word is copied into shreg and its parity latched at load time,
  // so later FIFO or in_data activity cannot disturb the frame on the wire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      tx      <= 1'b1;
      cnt     <= '0;
      idx     <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          tx  <= 1'b1;
          cnt <= '0;
          if (pop) begin
            shreg   <= head;
            par_bit <= (PAR == 2) ? ~(^head) : (^head);
            state   <= ST_START;
            tx      <= 1'b0;
          end
        end

        ST_START: begin
          if (bit_end) begin
            cnt   <= '0;
            idx   <= '0;
            state <= ST_DATA;
            tx    <= shreg[0];
            shreg <= shreg >> 1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (idx == IDX_LAST) begin
              if (PEN) begin
                state <= ST_PARITY;
                tx    <= par_bit;
              end else begin
                state <= ST_STOP;
                tx    <= 1'b1;
              end
            end else begin
              idx   <= idx + 1'b1;
              tx    <= shreg[0];
              shreg <= shreg >> 1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_PARITY: begin
          if (bit_end) begin
            cnt   <= '0;
            state <= ST_STOP;
            tx    <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_STOP: begin
          if (stop_end) begin
            cnt <= '0;
            if (pop) begin
              shreg   <= head;
              par_bit <= (PAR == 2) ? ~(^head) : (^head);
              state   <= ST_START;
              tx      <= 1'b0;
            end else begin
              state <= ST_IDLE;
              tx    <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
          tx    <= 1'b1;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo across five parameter sets sharing one clock and reset.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic [7:0] in_data_a  [5];
  logic       in_valid_a [5];
  logic       ready_w    [5];
  logic       tx_w       [5];
  logic       busy_w     [5];
  logic [2:0] level_w    [5];

  int n_cmp = 0;
  int n_bad = 0;

  logic       tx_c  [400];
  logic       busy_c[400];
  logic       rdy_c [400];
  logic [2:0] lvl_c [400];
  logic [7:0] wq    [8];

  always #5 clk = ~clk;

  uart_tx_fifo_if #(.W(8)) bus0 ();
  uart_tx_fifo_if #(.W(8)) bus1 ();
  uart_tx_fifo_if #(.W(8)) bus2 ();
  uart_tx_fifo_if #(.W(8)) bus3 ();
  uart_tx_fifo_if #(.W(8)) bus4 ();

  assign bus0.in_data = in_data_a[0];  assign bus0.in_valid = in_valid_a[0];  assign ready_w[0] = bus0.in_ready;
  assign bus1.in_data = in_data_a[1];  assign bus1.in_valid = in_valid_a[1];  assign ready_w[1] = bus1.in_ready;
  assign bus2.in_data = in_data_a[2];  assign bus2.in_valid = in_valid_a[2];  assign ready_w[2] = bus2.in_ready;
  assign bus3.in_data = in_data_a[3];  assign bus3.in_valid = in_valid_a[3];  assign ready_w[3] = bus3.in_ready;
  assign bus4.in_data = in_data_a[4];  assign bus4.in_valid = in_valid_a[4];  assign ready_w[4] = bus4.in_ready;

  uart_tx_fifo #(.W(8), .DIV(4), .PAR(0), .STOP(1), .DEPTH(4)) u0 (
    .clk(clk), .rst(rst), .s(bus0), .tx(tx_w[0]), .busy(busy_w[0]), .level(level_w[0]));
  uart_tx_fifo #(.W(8), .DIV(2), .PAR(1), .STOP(1), .DEPTH(4)) u1 (
    .clk(clk), .rst(rst), .s(bus1), .tx(tx_w[1]), .busy(busy_w[1]), .level(level_w[1]));
  uart_tx_fifo #(.W(8), .DIV(2), .PAR(2), .STOP(1), .DEPTH(4)) u2 (
    .clk(clk), .rst(rst), .s(bus2), .tx(tx_w[2]), .busy(busy_w[2]), .level(level_w[2]));
  uart_tx_fifo #(.W(8), .DIV(3), .PAR(0), .STOP(2), .DEPTH(4)) u3 (
    .clk(clk), .rst(rst), .s(bus3), .tx(tx_w[3]), .busy(busy_w[3]), .level(level_w[3]));
  uart_tx_fifo #(.W(8), .DIV(1), .PAR(0), .STOP(1), .DEPTH(4)) u4 (
    .clk(clk), .rst(rst), .s(bus4), .tx(tx_w[4]), .busy(busy_w[4]), .level(level_w[4]));

  // Expected line level c clocks after the start edge of a frame carrying d.
  function automatic logic exp_bit(input logic [7:0] d, input int c, input int div,
                                   input int par, input int stop);
    int b;
    b = c / div;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (par != 0 && b == 9) return (par == 1) ? ^d : ~(^d);
    return 1'b1;
  endfunction

  // Holds in_valid high until nw words from wq are accepted; sample 0 follows the first push edge.
  task automatic run_stream(input int u, input int nw, input int ncyc);
    int  sent;
    logic wp;
    @(negedge clk);
    sent = 0;
    in_valid_a[u] = 1'b1;
    in_data_a[u]  = wq[0];
    wp = ready_w[u];
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (wp) sent++;
      tx_c[i]   = tx_w[u];
      busy_c[i] = busy_w[u];
      rdy_c[i]  = ready_w[u];
      lvl_c[i]  = level_w[u];
      in_valid_a[u] = (sent < nw);
      in_data_a[u]  = (sent < nw) ? wq[sent] : 8'hFF;
      wp = in_valid_a[u] && ready_w[u];
    end
    in_valid_a[u] = 1'b0;
  endtask

  task automatic test_reset;
    #2 rst = 1'b1;
    #1;
    for (int u = 0; u < 5; u++) begin
      n_cmp++; if (tx_w[u] !== 1'b1)     begin n_bad++; $display("FAIL reset_tx u%0d: got %b want 1", u, tx_w[u]); end
      n_cmp++; if (busy_w[u] !== 1'b0)   begin n_bad++; $display("FAIL reset_busy u%0d: got %b want 0", u, busy_w[u]); end
      n_cmp++; if (level_w[u] !== 3'd0)  begin n_bad++; $display("FAIL reset_level u%0d: got %0d want 0", u, level_w[u]); end
      n_cmp++; if (ready_w[u] !== 1'b1)  begin n_bad++; $display("FAIL reset_ready u%0d: got %b want 1", u, ready_w[u]); end
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_frame_55;
    logic [9:0] exp;
    int bc;
    exp = 10'b1010101010;
    wq[0] = 8'h55;
    run_stream(0, 1, 45);
    n_cmp++; if (tx_c[0] !== 1'b1 || lvl_c[0] !== 3'd1)
      begin n_bad++; $display("FAIL f55_after_push: got tx=%b lvl=%0d want tx=1 lvl=1", tx_c[0], lvl_c[0]); end
    for (int s = 1; s <= 40; s++) begin
      n_cmp++; if (tx_c[s] !== exp[(s-1)/4])
        begin n_bad++; $display("FAIL f55_tx cyc%0d: got %b want %b", s-1, tx_c[s], exp[(s-1)/4]); end
    end
    bc = 0;
    for (int s = 0; s < 45; s++) if (busy_c[s] === 1'b1) bc++;
    n_cmp++; if (bc !== 40) begin n_bad++; $display("FAIL f55_busy_len: got %0d want 40", bc); end
    n_cmp++; if (tx_c[41] !== 1'b1 || busy_c[41] !== 1'b0 || lvl_c[41] !== 3'd0)
      begin n_bad++; $display("FAIL f55_end: got tx=%b busy=%b lvl=%0d want 1 0 0", tx_c[41], busy_c[41], lvl_c[41]); end
  endtask

  task automatic test_parity;
    logic [10:0] exp;
    int bc;
    for (int t = 0; t < 3; t++) begin
      case (t)
        0: begin wq[0] = 8'h07; exp = 11'b11000001110; end
        1: begin wq[0] = 8'h03; exp = 11'b10000000110; end
        default: begin wq[0] = 8'h07; exp = 11'b10000001110; end
      endcase
      run_stream((t == 2) ? 2 : 1, 1, 25);
      for (int s = 1; s <= 22; s++) begin
        n_cmp++; if (tx_c[s] !== exp[(s-1)/2])
          begin n_bad++; $display("FAIL parity%0d_tx cyc%0d: got %b want %b", t, s-1, tx_c[s], exp[(s-1)/2]); end
      end
      bc = 0;
      for (int s = 0; s < 25; s++) if (busy_c[s] === 1'b1) bc++;
      n_cmp++; if (bc !== 22) begin n_bad++; $display("FAIL parity%0d_busy_len: got %0d want 22", t, bc); end
    end
  endtask

  task automatic test_stop2;
    int bc;
    logic e;
    wq[0] = 8'hA5; wq[1] = 8'h3C;
    run_stream(3, 2, 70);
    for (int s = 1; s <= 66; s++) begin
      e = exp_bit(wq[(s-1)/33], (s-1) % 33, 3, 0, 2);
      n_cmp++; if (tx_c[s] !== e)
        begin n_bad++; $display("FAIL stop2_tx cyc%0d: got %b want %b", s-1, tx_c[s], e); end
    end
    bc = 0;
    for (int s = 0; s < 70; s++) if (busy_c[s] === 1'b1) bc++;
    n_cmp++; if (bc !== 66) begin n_bad++; $display("FAIL stop2_busy_len: got %0d want 66", bc); end
    n_cmp++; if (tx_c[67] !== 1'b1 || busy_c[67] !== 1'b0)
      begin n_bad++; $display("FAIL stop2_end: got tx=%b busy=%b want 1 0", tx_c[67], busy_c[67]); end
  endtask

  task automatic test_back_to_back;
    int bc;
    logic e;
    for (int i = 0; i < 8; i++) wq[i] = 8'(i + 1);
    run_stream(0, 8, 330);
    n_cmp++; if (lvl_c[3] !== 3'd3 || rdy_c[3] !== 1'b1)
      begin n_bad++; $display("FAIL b2b_lvl3: got lvl=%0d rdy=%b want 3 1", lvl_c[3], rdy_c[3]); end
    n_cmp++; if (lvl_c[4] !== 3'd4 || rdy_c[4] !== 1'b0)
      begin n_bad++; $display("FAIL b2b_full: got lvl=%0d rdy=%b want 4 0", lvl_c[4], rdy_c[4]); end
    for (int s = 1; s <= 320; s++) begin
      e = exp_bit(wq[(s-1)/40], (s-1) % 40, 4, 0, 1);
      n_cmp++; if (tx_c[s] !== e)
        begin n_bad++; $display("FAIL b2b_tx cyc%0d: got %b want %b", s-1, tx_c[s], e); end
    end
    bc = 0;
    for (int s = 1; s <= 320; s++) if (busy_c[s] === 1'b1) bc++;
    n_cmp++; if (bc !== 320) begin n_bad++; $display("FAIL b2b_busy_cont: got %0d want 320", bc); end
    n_cmp++; if (tx_c[321] !== 1'b1 || busy_c[321] !== 1'b0 || lvl_c[321] !== 3'd0)
      begin n_bad++; $display("FAIL b2b_end: got tx=%b busy=%b lvl=%0d want 1 0 0", tx_c[321], busy_c[321], lvl_c[321]); end
  endtask

  task automatic test_div1;
    logic e;
    wq[0] = 8'h96; wq[1] = 8'h5A; wq[2] = 8'h0F;
    wq[3] = 8'hF0; wq[4] = 8'h81; wq[5] = 8'h3C;
    run_stream(4, 6, 64);
    n_cmp++; if (lvl_c[1] !== 3'd1)
      begin n_bad++; $display("FAIL div1_push_pop: got lvl=%0d want 1", lvl_c[1]); end
    n_cmp++; if (lvl_c[4] !== 3'd4 || rdy_c[4] !== 1'b0)
      begin n_bad++; $display("FAIL div1_full: got lvl=%0d rdy=%b want 4 0", lvl_c[4], rdy_c[4]); end
    n_cmp++; if (lvl_c[11] !== 3'd3 || lvl_c[12] !== 3'd4)
      begin n_bad++; $display("FAIL div1_refill: got %0d,%0d want 3,4", lvl_c[11], lvl_c[12]); end
    for (int s = 1; s <= 60; s++) begin
      e = exp_bit(wq[(s-1)/10], (s-1) % 10, 1, 0, 1);
      n_cmp++; if (tx_c[s] !== e)
        begin n_bad++; $display("FAIL div1_tx cyc%0d: got %b want %b", s-1, tx_c[s], e); end
    end
    n_cmp++; if (tx_c[61] !== 1'b1 || busy_c[61] !== 1'b0)
      begin n_bad++; $display("FAIL div1_end: got tx=%b busy=%b want 1 0", tx_c[61], busy_c[61]); end
  endtask

  task automatic test_reset_mid_frame;
    int bad_idle;
    wq[0] = 8'h11; wq[1] = 8'h22; wq[2] = 8'h33;
    run_stream(0, 3, 18);
    n_cmp++; if (lvl_c[17] !== 3'd2 || busy_c[17] !== 1'b1 || tx_c[17] !== 1'b0)
      begin n_bad++; $display("FAIL rstmid_pre: got lvl=%0d busy=%b tx=%b want 2 1 0", lvl_c[17], busy_c[17], tx_c[17]); end
    rst = 1'b1;
    #1;
    n_cmp++; if (tx_w[0] !== 1'b1)    begin n_bad++; $display("FAIL rstmid_tx: got %b want 1", tx_w[0]); end
    n_cmp++; if (busy_w[0] !== 1'b0)  begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", busy_w[0]); end
    n_cmp++; if (level_w[0] !== 3'd0) begin n_bad++; $display("FAIL rstmid_level: got %0d want 0", level_w[0]); end
    in_valid_a[0] = 1'b1;
    in_data_a[0]  = 8'h77;
    repeat (2) @(negedge clk);
    in_valid_a[0] = 1'b0;
    rst = 1'b0;
    n_cmp++; if (level_w[0] !== 3'd0) begin n_bad++; $display("FAIL rstmid_no_push: got %0d want 0", level_w[0]); end
    bad_idle = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) bad_idle++;
    end
    n_cmp++; if (bad_idle !== 0) begin n_bad++; $display("FAIL rstmid_idle: got %0d active cycles want 0", bad_idle); end
    wq[0] = 8'h55;
    run_stream(0, 1, 6);
    n_cmp++; if (tx_c[1] !== 1'b0 || busy_c[1] !== 1'b1)
      begin n_bad++; $display("FAIL rstmid_restart: got tx=%b busy=%b want 0 1", tx_c[1], busy_c[1]); end
    n_cmp++; if (tx_c[5] !== 1'b1)
      begin n_bad++; $display("FAIL rstmid_restart_d0: got %b want 1", tx_c[5]); end
    repeat (45) @(negedge clk);
  endtask

  initial begin
    for (int u = 0; u < 5; u++) begin
      in_valid_a[u] = 1'b0;
      in_data_a[u]  = 8'h00;
    end
    test_reset;
    test_frame_55;
    test_parity;
    test_stop2;
    test_back_to_back;
    test_div1;
    test_reset_mid_frame;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
